// File: rtl/alu_response_checker.sv
// Self-checking monitor for a 4-bit ALU: runs NUM_VECTORS accepted samples
// through a two-stage compare pipeline and reports a saturating error count.
module alu_response_checker #(
    parameter int NUM_VECTORS = 16,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic [3:0]       ALU_Sel,
    input  logic [7:0]       ALU_Out,
    input  logic             CarryOut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_err_sel,
    output logic             first_err_seen
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] got_out;
        logic       got_cy;
        logic [7:0] exp_out;
        logic       exp_cy;
    } sample_t;

    localparam logic [7:0]       LAST_VEC = 8'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    function automatic logic [7:0] alu_ref(input logic [3:0] a4, input logic [3:0] b4,
                                           input logic [3:0] sel);
        logic [7:0] a, b, r;
        a = {4'b0, a4};
        b = {4'b0, b4};
        case (sel)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a * b;
            4'd3:    r = (b == 8'd0) ? 8'h00 : a / b;
            4'd4:    r = a << 1;
            4'd5:    r = a >> 1;
            4'd6:    r = {a[6:0], a[7]};
            4'd7:    r = {a[0], a[7:1]};
            4'd8:    r = a & b;
            4'd9:    r = a | b;
            4'd10:   r = a ^ b;
            4'd11:   r = ~(a | b);
            4'd12:   r = ~(a & b);
            4'd13:   r = ~(a ^ b);
            4'd14:   r = {7'b0, (a4 > b4)};
            default: r = {7'b0, (a4 == b4)};
        endcase
        return r;
    endfunction

    state_t     state;
    logic [7:0] vec_cnt;
    logic       drain_cnt;
    logic       s1_vld;
    sample_t    s1;
    sample_t    cur;
    logic [4:0] sum5;
    logic       xfer;
    logic       mismatch;

    assign xfer = in_valid & in_ready;
    assign sum5 = {1'b0, A} + {1'b0, B};

    always_comb begin
        cur         = '0;
        cur.sel     = ALU_Sel;
        cur.got_out = ALU_Out;
        cur.got_cy  = CarryOut;
        cur.exp_out = alu_ref(A, B, ALU_Sel);
        cur.exp_cy  = sum5[4];
    end

    assign mismatch = s1_vld && ((s1.got_out != s1.exp_out) || (s1.got_cy != s1.exp_cy));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            vec_cnt        <= '0;
            drain_cnt      <= 1'b0;
            s1_vld         <= 1'b0;
            s1             <= '0;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_sel  <= '0;
            first_err_seen <= 1'b0;
        end else begin
            // Stage 1: capture the accepted sample with its expected values.
            s1_vld <= xfer;
            if (xfer) s1 <= cur;

            // Stage 2: compare and accumulate.
            if (mismatch) begin
                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                if (!first_err_seen) begin
                    first_err_seen <= 1'b1;
                    first_err_sel  <= s1.sel;
                end
            end

            // Placed after stage 2 so a run restart clear takes priority.
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_RUN;
                        vec_cnt        <= '0;
                        s1_vld         <= 1'b0;
                        err_count      <= '0;
                        first_err_sel  <= '0;
                        first_err_seen <= 1'b0;
                        in_ready       <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        vec_cnt <= vec_cnt + 8'd1;
                        if (vec_cnt == LAST_VEC) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 1'b0;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    // Last sample retired on the previous edge, so err_count is final.
                    if (drain_cnt) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_response_checker.sv
// Randomized self-checking bench for alu_response_checker with a small
// arithmetic reference model; a second instance with ERR_W=2 covers saturation.
module tb_alu_response_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] A = '0, B = '0, ALU_Sel = '0;
    logic [7:0] ALU_Out = '0;
    logic       CarryOut = 1'b0;

    logic       in_ready, busy, done, pass, first_err_seen;
    logic [7:0] err_count;
    logic [3:0] first_err_sel;
    logic       in_ready2, busy2, done2, pass2, first_err_seen2;
    logic [1:0] err_count2;
    logic [3:0] first_err_sel2;

    int total = 0;
    int passed = 0;

    int m_err, m_xfers, m_first_sel;
    bit m_first_seen;

    always #5 clk = ~clk;

    alu_response_checker #(.NUM_VECTORS(16), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .CarryOut(CarryOut),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_sel(first_err_sel), .first_err_seen(first_err_seen));

    alu_response_checker #(.NUM_VECTORS(16), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .CarryOut(CarryOut),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .first_err_sel(first_err_sel2), .first_err_seen(first_err_seen2));

    function automatic logic [7:0] ref_out(input logic [3:0] av, input logic [3:0] bv,
                                           input logic [3:0] sel);
        int a, b, r;
        a = av;
        b = bv;
        case (sel)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            3: r = (b == 0) ? 0 : a / b;
            4: r = a * 2;
            5: r = a / 2;
            6: r = a * 2;                       // operand < 16, so nothing wraps around
            7: r = a / 2 + (a % 2) * 128;
            8: r = a & b;
            9: r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        r = r & 255;
        return r[7:0];
    endfunction

    function automatic logic ref_cy(input logic [3:0] av, input logic [3:0] bv);
        int s;
        s = av + bv;
        return (s >= 16);
    endfunction

    task automatic model_clear();
        m_err = 0; m_xfers = 0; m_first_sel = 0; m_first_seen = 0;
    endtask

    // Drive one sample for one edge; the model records it only if accepted.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                        input logic [7:0] o, input logic cy);
        A = a; B = b; ALU_Sel = sel; ALU_Out = o; CarryOut = cy; in_valid = 1'b1;
        if (in_ready) begin
            m_xfers++;
            if (o != ref_out(a, b, sel) || cy != ref_cy(a, b)) begin
                m_err++;
                if (!m_first_seen) begin m_first_seen = 1; m_first_sel = sel; end
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin ok = 1; return; end
            @(negedge clk);
        end
    endtask

    task automatic sweep(input int fault_sel);
        for (int s = 0; s < 16; s++) begin
            logic [3:0] sl;
            logic [7:0] o;
            sl = 4'(s);
            o = (s == fault_sel) ? 8'h00 : ref_out(4'hA, 4'h2, sl);
            send(4'hA, 4'h2, sl, o, ref_cy(4'hA, 4'h2));
        end
    endtask

    task automatic test_reset();
        total++; if ({in_ready, busy, done, pass} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {in_ready, busy, done, pass}); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL reset_err got %0d want 0", err_count); else passed++;
        total++; if ({first_err_seen, first_err_sel} !== 5'b0) $display("FAIL reset_first got %b want 0", {first_err_seen, first_err_sel}); else passed++;
    endtask

    task automatic test_clean_sweep();
        pulse_start();
        total++; if ({busy, in_ready, done} !== 3'b110) $display("FAIL run_flags got %b want 110", {busy, in_ready, done}); else passed++;
        sweep(-1);
        // Now one cycle after the last transfer edge: draining.
        total++; if ({busy, in_ready, done} !== 3'b100) $display("FAIL drain1_flags got %b want 100", {busy, in_ready, done}); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL drain2_done got %b want 0", done); else passed++;
        @(negedge clk);
        total++; if ({done, pass, busy} !== 3'b110) $display("FAIL sweep_done got %b want 110", {done, pass, busy}); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL sweep_err got %0d want 0", err_count); else passed++;
    endtask

    task automatic test_single_fault();
        bit ok;
        // Restart straight from DONE of the previous run.
        pulse_start();
        total++; if ({busy, done, first_err_seen} !== 3'b100) $display("FAIL restart_flags got %b want 100", {busy, done, first_err_seen}); else passed++;
        for (int s = 0; s < 3; s++) send(4'hA, 4'h2, 4'(s), ref_out(4'hA, 4'h2, 4'(s)), 1'b0);
        send(4'hA, 4'h2, 4'd3, 8'h00, 1'b0);
        total++; if (err_count !== 8'd0) $display("FAIL fault_early got %0d want 0", err_count); else passed++;
        send(4'hA, 4'h2, 4'd4, ref_out(4'hA, 4'h2, 4'd4), 1'b0);
        total++; if (err_count !== 8'd1) $display("FAIL fault_lat got %0d want 1", err_count); else passed++;
        for (int s = 5; s < 16; s++) send(4'hA, 4'h2, 4'(s), ref_out(4'hA, 4'h2, 4'(s)), 1'b0);
        wait_done(ok);
        total++; if (!ok) $display("FAIL fault_timeout got done=0 want done=1"); else passed++;
        total++; if ({err_count, first_err_sel, first_err_seen, pass} !== {8'd1, 4'd3, 1'b1, 1'b0})
            $display("FAIL fault_result got err=%0d sel=%0d seen=%b pass=%b want 1 3 1 0", err_count, first_err_sel, first_err_seen, pass);
        else passed++;
    endtask

    task automatic test_edges();
        bit ok;
        pulse_start();
        send(4'hF, 4'h1, 4'd0, 8'h10, 1'b1);
        send(4'h7, 4'h0, 4'd3, 8'h00, 1'b0);
        @(negedge clk);
        total++; if (err_count !== 8'd0) $display("FAIL edge_noerr got %0d want 0", err_count); else passed++;
        send(4'hF, 4'h1, 4'd0, 8'h10, 1'b0);
        for (int i = 0; i < 13; i++) begin
            logic [3:0] a, b, s;
            a = 4'($urandom); b = 4'($urandom); s = 4'($urandom);
            send(a, b, s, ref_out(a, b, s), ref_cy(a, b));
        end
        wait_done(ok);
        total++; if (!ok) $display("FAIL edge_timeout got done=0 want done=1"); else passed++;
        total++; if ({err_count, first_err_sel} !== {8'd1, 4'd0}) $display("FAIL edge_carry got err=%0d sel=%0d want 1 0", err_count, first_err_sel); else passed++;
    endtask

    task automatic test_random(input int runs);
        bit ok;
        for (int r = 0; r < runs; r++) begin
            pulse_start();
            for (int i = 0; i < 16; i++) begin
                logic [3:0] a, b, s;
                logic [7:0] o;
                logic cy;
                int kind;
                a = 4'($urandom); b = 4'($urandom); s = 4'($urandom);
                o = ref_out(a, b, s); cy = ref_cy(a, b);
                kind = $urandom_range(0, 3);
                if (kind == 1) o = o ^ (8'd1 << $urandom_range(0, 7));
                if (kind == 2) cy = ~cy;
                send(a, b, s, o, cy);
            end
            wait_done(ok);
            total++; if (!ok) $display("FAIL rand_timeout run %0d", r); else passed++;
            total++; if (err_count !== 8'(m_err)) $display("FAIL rand_err got %0d want %0d", err_count, m_err); else passed++;
            total++; if (err_count2 !== 2'((m_err > 3) ? 3 : m_err)) $display("FAIL rand_err2 got %0d want %0d", err_count2, (m_err > 3) ? 3 : m_err); else passed++;
            total++; if (first_err_seen !== m_first_seen || (m_first_seen && first_err_sel !== 4'(m_first_sel)))
                $display("FAIL rand_first got seen=%b sel=%0d want %b %0d", first_err_seen, first_err_sel, m_first_seen, m_first_sel);
            else passed++;
            total++; if (pass !== (m_err == 0)) $display("FAIL rand_pass got %b want %b", pass, (m_err == 0)); else passed++;
        end
    endtask

    task automatic test_handshake_gaps();
        int xfers;
        int hold_err;
        xfers = 0;
        pulse_start();
        for (int c = 0; c < 100 && !done; c++) begin
            logic [3:0] a, b, s;
            a = 4'($urandom); b = 4'($urandom); s = 4'($urandom);
            A = a; B = b; ALU_Sel = s; ALU_Out = ref_out(a, b, s); CarryOut = ref_cy(a, b);
            in_valid = (c % 2 == 0);
            start = (c == 5);                   // must be ignored mid-run
            if (in_valid && in_ready) xfers++;
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (done !== 1'b1) $display("FAIL gap_timeout got done=%b want 1", done); else passed++;
        total++; if (xfers !== 16) $display("FAIL gap_xfers got %0d want 16", xfers); else passed++;
        hold_err = err_count;
        ALU_Out = ~ref_out(A, B, ALU_Sel);
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        total++; if ({done, in_ready} !== 2'b10 || err_count !== 8'(hold_err) || hold_err != 0)
            $display("FAIL gap_done_hold got done=%b rdy=%b err=%0d want 1 0 0", done, in_ready, err_count);
        else passed++;
    endtask

    task automatic test_saturation();
        bit ok;
        logic [3:0] fs;
        fs = 4'($urandom);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a, b, s;
            a = 4'($urandom); b = 4'($urandom);
            s = (i == 0) ? fs : 4'($urandom);
            send(a, b, s, ~ref_out(a, b, s), ref_cy(a, b));
        end
        wait_done(ok);
        total++; if (!ok) $display("FAIL sat_timeout got done=0 want 1"); else passed++;
        total++; if ({err_count2, first_err_sel2, pass2} !== {2'd3, fs, 1'b0})
            $display("FAIL sat_small got err=%0d sel=%0d pass=%b want 3 %0d 0", err_count2, first_err_sel2, pass2, fs);
        else passed++;
        total++; if (err_count !== 8'd16) $display("FAIL sat_wide got %0d want 16", err_count); else passed++;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            logic [7:0] o;
            o = ref_out(4'h3, 4'h5, 4'(i));
            send(4'h3, 4'h5, 4'(i), (i == 1) ? ~o : o, 1'b0);
        end
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if ({in_ready, busy, done, pass, first_err_seen} !== 5'b0 || err_count !== 8'd0 || first_err_sel !== 4'd0)
            $display("FAIL midrun_rst got rdy=%b busy=%b done=%b pass=%b err=%0d sel=%0d seen=%b want all 0",
                     in_ready, busy, done, pass, err_count, first_err_sel, first_err_seen);
        else passed++;
        total++; if (err_count2 !== 2'd0) $display("FAIL midrun_rst2 got %0d want 0", err_count2); else passed++;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL midrun_idle got busy=%b want 0", busy); else passed++;
        pulse_start();
        sweep(-1);
        wait_done(ok);
        total++; if (!ok || pass !== 1'b1 || err_count !== 8'd0)
            $display("FAIL midrun_resweep got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count);
        else passed++;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_clean_sweep();
        test_single_fault();
        test_edges();
        test_random(4);
        test_handshake_gaps();
        test_saturation();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_response_checker.md
ALU_RESPONSE_CHECKER -- requirements
Module: alu_response_checker

Interface
REQ-001 Parameter: NUM_VECTORS, default 16, number of accepted samples per run (1..255).
REQ-002 Parameter: ERR_W, default 8, width of the error counter.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  one-cycle pulse that begins a run.
REQ-006 Port: in_valid  input  1  sample below is valid this cycle.
REQ-007 Port: in_ready  output  1  checker accepts a sample this cycle.
REQ-008 Port: A  input  4  operand A applied to the ALU.
REQ-009 Port: B  input  4  operand B applied to the ALU.
REQ-010 Port: ALU_Sel  input  4  opcode applied to the ALU.
REQ-011 Port: ALU_Out  input  8  ALU result under test.
REQ-012 Port: CarryOut  input  1  ALU carry flag under test.
REQ-013 Port: busy  output  1  high in RUN and DRAIN.
REQ-014 Port: done  output  1  high in DONE.
REQ-015 Port: pass  output  1  high in DONE when err_count is zero.
REQ-016 Port: err_count  output  ERR_W  mismatching samples in current or last run, saturating.
REQ-017 Port: first_err_sel  output  4  ALU_Sel of the first mismatching sample.
REQ-018 Port: first_err_seen  output  1  first_err_sel holds a valid value.

Function
REQ-019 Transfer occurs on a rising edge where in_valid and in_ready are both 1; no other cycle samples inputs.
REQ-020 Expected result, with a = {4'b0,A} and b = {4'b0,B}: 0 a+b; 1 a-b (8-bit wrap); 2 a*b; 3 a/b; 4 a<<1; 5 a>>1; 6 rotate-left-1 of a; 7 rotate-right-1 of a; 8 a&b; 9 a|b; 10 a^b; 11 ~(a|b); 12 ~(a&b); 13 ~(a^b); 14 8'd1 if A>B else 0; 15 8'd1 if A==B else 0.
REQ-021 Opcode 3 with B==0: expected result 8'h00.
REQ-022 Expected carry is bit 4 of the 5-bit sum A+B for every opcode.
REQ-023 Mismatch means ALU_Out differs from expected result, or CarryOut differs from expected carry.
REQ-024 Two-stage pipeline: stage 1 registers the accepted sample and its expected values; stage 2 compares and updates counters. err_count reflects a sample 2 cycles after its transfer.
REQ-025 States: IDLE, RUN, DRAIN, DONE.
REQ-026 IDLE: in_ready=0, busy=0, done=0; start -> RUN.
REQ-027 IDLE or DONE on start -> RUN: clear err_count, first_err_seen, first_err_sel, and the vector counter.
REQ-028 RUN: in_ready=1; vector counter increments per transfer; the transfer that reaches NUM_VECTORS -> DRAIN.
REQ-029 DRAIN: in_ready=0; lasts exactly 2 cycles so both pipeline stages retire; then DONE.
REQ-030 DONE: done=1, pass=(err_count==0), in_ready=0; results hold until start or rst.
REQ-031 start during RUN or DRAIN is ignored.
REQ-032 err_count saturates at all-ones and does not wrap.
REQ-033 On the first mismatch of a run, capture first_err_sel and set first_err_seen; later mismatches do not change them.
REQ-034 in_valid while in_ready=0 has no effect.

Reset
REQ-035 rst=1 at a rising edge: state=IDLE; pipeline valid bits cleared; all outputs 0 (in_ready, busy, done, pass, err_count, first_err_sel, first_err_seen).
REQ-036 rst overrides start and transfers in the same cycle, including mid-run; the partial run is discarded.

Verification
REQ-037 Correct-ALU sweep: start; A=4'hA, B=4'h2, ALU_Sel 0..15, correct outputs (e.g. sel0 -> 8'h0C with carry 0) -> done after last transfer + 2 cycles + 1 cycle into DONE; pass=1, err_count=0.
REQ-038 Single fault: same sweep with ALU_Out at sel=3 forced to 8'h00 (expected 8'h05) -> err_count=1, first_err_sel=3, first_err_seen=1, pass=0.
REQ-039 Carry and divide edges: A=4'hF, B=4'h1, sel=0, out 8'h10, carry 1 -> no error; A=4'h7, B=0, sel=3, out 8'h00 -> no error; same with carry 0 on sel=0 -> err_count increments.
REQ-040 Handshake gaps: in_valid toggled every other cycle in RUN -> exactly NUM_VECTORS transfers; in_valid held in DONE -> no counter change.
REQ-041 Saturation: ERR_W=2, 16 faulty samples -> err_count=3, first_err_sel equals the sel of the first sample.
REQ-042 Reset mid-run: rst asserted after 7 transfers -> next cycle all outputs 0, IDLE; a new start runs a full clean sweep to pass=1.
